// File: rtl/mapper_multicart_gen_pkg.sv
// Shared constants for the generic multicart mapper: PRG banking modes,
// nametable mirroring selections and the CHR region base.
package mapper_multicart_gen_pkg;

  typedef enum logic [1:0] {
    PRG_32K        = 2'd0,
    PRG_16K_MIRROR = 2'd1,
    PRG_16K_FIXHI  = 2'd2,
    PRG_32K_ALT    = 2'd3
  } prg_mode_e;

  typedef enum logic [1:0] {
    MIR_VERT  = 2'd0,
    MIR_HORZ  = 2'd1,
    MIR_ONE_A = 2'd2,
    MIR_ONE_B = 2'd3
  } mirror_e;

  localparam logic [2:0] CHR_BASE = 3'b100;

endpackage

// File: rtl/mapper_irq_timer.sv
// CPU-cycle down-counting IRQ timer with reload latch; ce-gated.
module mapper_irq_timer
  import mapper_multicart_gen_pkg::*;
#(
  parameter int unsigned IRQ_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       latch_lo_we,
  input  logic       latch_hi_we,
  input  logic       ctrl_we,
  input  logic [7:0] din,
  output logic       irq
);

  logic [IRQ_W-1:0] latch_q;
  logic [IRQ_W-1:0] cnt_q;
  logic             en_q;
  logic             irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else if (ce) begin
      if (latch_lo_we) latch_q[7:0]       <= din;
      if (latch_hi_we) latch_q[IRQ_W-1:8] <= din[IRQ_W-9:0];
      // A control write takes priority over an expiry in the same cycle.
      if (ctrl_we) begin
        en_q  <= din[0];
        irq_q <= 1'b0;
        if (din[1]) cnt_q <= latch_q;
      end else if (en_q) begin
        if (cnt_q <= IRQ_W'(1)) begin
          irq_q <= 1'b1;
          cnt_q <= latch_q;
        end else begin
          cnt_q <= cnt_q - IRQ_W'(1);
        end
      end
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/mapper_multicart_gen.sv
// Generic multicart mapper: lockable PRG/CHR banking, four-way mirroring
// and a CPU-cycle IRQ timer.
module mapper_multicart_gen
  import mapper_multicart_gen_pkg::*;
#(
  parameter int unsigned PRG_BANK_W = 5,
  parameter int unsigned CHR_BANK_W = 6,
  parameter int unsigned IRQ_W      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  output logic [21:0] prg_aout,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  output logic        prg_allow,
  input  logic [13:0] chr_ain,
  output logic [21:0] chr_aout,
  output logic        chr_allow,
  output logic        vram_a10,
  output logic        vram_ce,
  output logic        irq
);

  logic [PRG_BANK_W-1:0] prg_bank_q;
  prg_mode_e             prg_mode_q;
  logic [CHR_BANK_W-1:0] chr_bank_q;
  mirror_e               mirror_q;
  logic                  lock_q;

  logic       wr;
  logic [1:0] sel;
  assign wr  = ce & prg_write & prg_ain[15];
  assign sel = prg_ain[14:13];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prg_bank_q <= '0;
      prg_mode_q <= PRG_32K;
      chr_bank_q <= '0;
      mirror_q   <= MIR_VERT;
      lock_q     <= 1'b0;
    end else if (wr) begin
      if (sel == 2'b00 && !lock_q) begin
        prg_bank_q <= prg_din[PRG_BANK_W-1:0];
        prg_mode_q <= prg_mode_e'(prg_ain[1:0]);
      end
      if (sel == 2'b01 && !lock_q) begin
        chr_bank_q <= prg_din[CHR_BANK_W-1:0];
        mirror_q   <= mirror_e'(prg_ain[1:0]);
      end
      if (sel == 2'b11 && prg_din[7]) lock_q <= 1'b1;
    end
  end

  mapper_irq_timer #(
    .IRQ_W(IRQ_W)
  ) u_irq_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .latch_lo_we(wr && sel == 2'b10 && !prg_ain[0]),
    .latch_hi_we(wr && sel == 2'b10 && prg_ain[0]),
    .ctrl_we    (wr && sel == 2'b11),
    .din        (prg_din),
    .irq        (irq)
  );

  logic [PRG_BANK_W-1:0] prg_b;

  always_comb begin
    prg_b = prg_bank_q;
    unique case (prg_mode_q)
      PRG_16K_MIRROR: prg_b = prg_bank_q;
      PRG_16K_FIXHI:  prg_b = prg_ain[14] ? '1 : prg_bank_q;
      // 32K modes: bank LSB follows A14 (also valid for 1-bit banks).
      default:        prg_b[0] = prg_ain[14];
    endcase
    prg_aout = '0;
    prg_aout[PRG_BANK_W+13:0] = {prg_b, prg_ain[13:0]};
  end

  always_comb begin
    vram_a10 = chr_ain[10];
    unique case (mirror_q)
      MIR_VERT:  vram_a10 = chr_ain[10];
      MIR_HORZ:  vram_a10 = chr_ain[11];
      MIR_ONE_A: vram_a10 = 1'b0;
      MIR_ONE_B: vram_a10 = 1'b1;
    endcase
  end

  assign chr_aout  = {CHR_BASE, 6'(chr_bank_q), chr_ain[12:0]};
  assign prg_allow = prg_ain[15] & ~prg_write;
  assign chr_allow = flags[15];
  assign vram_ce   = chr_ain[13];

  logic unused_ok;
  assign unused_ok = &{1'b0, prg_read, flags[31:16], flags[14:0]};

endmodule

// File: tb/tb_mapper_multicart_gen.sv
// Directed bench for the generic multicart mapper: banking table plus
// IRQ timer and async reset sequences.
module tb_mapper_multicart_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] flags = '0;
  logic [15:0] prg_ain = '0;
  logic [21:0] prg_aout;
  logic        prg_read = 1'b0;
  logic        prg_write = 1'b0;
  logic [7:0]  prg_din = '0;
  logic        prg_allow;
  logic [13:0] chr_ain = '0;
  logic [21:0] chr_aout;
  logic        chr_allow;
  logic        vram_a10;
  logic        vram_ce;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mapper_multicart_gen #(
    .PRG_BANK_W(5),
    .CHR_BANK_W(6),
    .IRQ_W     (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .flags    (flags),
    .prg_ain  (prg_ain),
    .prg_aout (prg_aout),
    .prg_read (prg_read),
    .prg_write(prg_write),
    .prg_din  (prg_din),
    .prg_allow(prg_allow),
    .chr_ain  (chr_ain),
    .chr_aout (chr_aout),
    .chr_allow(chr_allow),
    .vram_a10 (vram_a10),
    .vram_ce  (vram_ce),
    .irq      (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    prg_ain   = a;
    prg_din   = d;
    prg_write = 1'b1;
    ce        = 1'b1;
    @(negedge clk);
    prg_write = 1'b0;
    ce        = 1'b0;
  endtask

  task automatic run_ce(input int n);
    ce = 1'b1;
    repeat (n) @(negedge clk);
    ce = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [13:0] ca;
    logic [21:0] ep;
    logic [21:0] ec;
    logic        ea10;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 8'h00, 16'hC123, 14'h0400, 22'h004123, 22'h200400, 1'b1};
    tbl[1]  = '{1'b0, 16'h0000, 8'h00, 16'h8000, 14'h0000, 22'h000000, 22'h200000, 1'b0};
    tbl[2]  = '{1'b1, 16'h8002, 8'h05, 16'h9000, 14'h0000, 22'h015000, 22'h200000, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 8'h00, 16'hD000, 14'h0000, 22'h07D000, 22'h200000, 1'b0};
    tbl[4]  = '{1'b1, 16'h8001, 8'h05, 16'hD000, 14'h0000, 22'h015000, 22'h200000, 1'b0};
    tbl[5]  = '{1'b1, 16'h8003, 8'h06, 16'hC000, 14'h0000, 22'h01C000, 22'h200000, 1'b0};
    tbl[6]  = '{1'b1, 16'h8000, 8'hFF, 16'hC000, 14'h0000, 22'h07C000, 22'h200000, 1'b0};
    tbl[7]  = '{1'b1, 16'hA001, 8'h03, 16'h8000, 14'h0010, 22'h078000, 22'h206010, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 8'h00, 16'h8000, 14'h0800, 22'h078000, 22'h206800, 1'b1};
    tbl[9]  = '{1'b1, 16'hA002, 8'h03, 16'h8000, 14'h0C00, 22'h078000, 22'h206C00, 1'b0};
    tbl[10] = '{1'b1, 16'hA003, 8'h3F, 16'h8000, 14'h0000, 22'h078000, 22'h27E000, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 8'h00, 16'h8000, 14'h1FFF, 22'h078000, 22'h27FFFF, 1'b1};
    tbl[12] = '{1'b1, 16'hE000, 8'h80, 16'hC000, 14'h0000, 22'h07C000, 22'h27E000, 1'b1};
    tbl[13] = '{1'b1, 16'h8000, 8'h07, 16'hC000, 14'h0000, 22'h07C000, 22'h27E000, 1'b1};
    tbl[14] = '{1'b1, 16'hA000, 8'h00, 16'h8000, 14'h0400, 22'h078000, 22'h27E400, 1'b1};

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr) do_write(tbl[i].wa, tbl[i].wd);
      prg_ain = tbl[i].ra;
      chr_ain = tbl[i].ca;
      #1;
      chk($sformatf("vec%0d_prg_aout", i), 32'(prg_aout), 32'(tbl[i].ep));
      chk($sformatf("vec%0d_chr_aout", i), 32'(chr_aout), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_vram_a10", i), 32'(vram_a10), 32'(tbl[i].ea10));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'd0);
    end

    prg_ain = 16'h8000; chr_ain = 14'h2000; flags = 32'h0000_8000; #1;
    chk("prg_allow_rd", 32'(prg_allow), 32'd1);
    chk("vram_ce_hi", 32'(vram_ce), 32'd1);
    chk("chr_allow_ram", 32'(chr_allow), 32'd1);
    prg_ain = 16'h7FFF; chr_ain = 14'h1000; flags = 32'hFFFF_7FFF; #1;
    chk("prg_allow_lo", 32'(prg_allow), 32'd0);
    chk("vram_ce_lo", 32'(vram_ce), 32'd0);
    chk("chr_allow_rom", 32'(chr_allow), 32'd0);

    // IRQ timer: latch writes still work while banking is locked.
    do_write(16'hC000, 8'h03);
    do_write(16'hC001, 8'h00);
    do_write(16'hE000, 8'h03);
    #1 chk("irq_after_arm", 32'(irq), 32'd0);
    run_ce(1); #1 chk("irq_cnt2", 32'(irq), 32'd0);
    run_ce(1); #1 chk("irq_cnt1", 32'(irq), 32'd0);
    run_ce(1); #1 chk("irq_fire", 32'(irq), 32'd1);
    run_ce(2); #1 chk("irq_held", 32'(irq), 32'd1);
    do_write(16'hE000, 8'h01);
    #1 chk("irq_ack", 32'(irq), 32'd0);
    // Counter was 1 after 3->2 after ack... re-arm with reload to count cleanly.
    do_write(16'hE000, 8'h03);
    run_ce(2);
    do_write(16'hE000, 8'h01);
    #1 chk("irq_collide", 32'(irq), 32'd0);
    run_ce(1); #1 chk("irq_after_collide", 32'(irq), 32'd1);

    // Asynchronous reset mid-count with irq asserted.
    @(negedge clk);
    #1 reset_n = 1'b0;
    prg_ain = 16'hC123; chr_ain = 14'h0400;
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_prg_aout", 32'(prg_aout), 32'h004123);
    chk("rst_chr_aout", 32'(chr_aout), 32'h200400);
    chk("rst_vram_a10", 32'(vram_a10), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    do_write(16'h8000, 8'h07);
    prg_ain = 16'hC000; #1;
    chk("unlock_after_rst", 32'(prg_aout), 32'h01C000);

    // Zero latch: every enabled ce cycle expires.
    do_write(16'hE000, 8'h01);
    run_ce(1); #1 chk("latch0_fire", 32'(irq), 32'd1);
    do_write(16'hE000, 8'h01);
    #1 chk("latch0_ack", 32'(irq), 32'd0);
    run_ce(1); #1 chk("latch0_refire", 32'(irq), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
